// File: rtl/next_pc_predictor.sv
// Fetch-PC register with a direct-mapped BTB of 2-bit saturating counters; EX-stage updates train it and redirects override.
// Optional BTB_STATS_EN adds stat_hits / stat_redirects counters.
module next_pc_predictor #(
  parameter int ADDR_W = 32,
  parameter int BTB_DEPTH = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_taken,
`ifdef BTB_STATS_EN
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_redirects,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic              btb_valid  [BTB_DEPTH];
  logic [TAG_W-1:0]  btb_tag    [BTB_DEPTH];
  logic [ADDR_W-1:0] btb_target [BTB_DEPTH];
  logic [1:0]        btb_ctr    [BTB_DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             hit;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;
  logic             unused_low_bits;

  assign rd_idx = pc[IDX_W+1:2];
  assign rd_tag = pc[ADDR_W-1:IDX_W+2];
  assign wr_idx = upd_pc[IDX_W+1:2];
  assign wr_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_low_bits = ^{pc[1:0], upd_pc[1:0]};

  assign hit         = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
  assign pred_taken  = hit && btb_ctr[rd_idx][1];
  assign pred_target = hit ? btb_target[rd_idx] : '0;
  assign wr_hit      = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (!stall) begin
      pc <= pred_taken ? pred_target : pc + ADDR_W'(4);
    end
  end

  // Lookup above reads the pre-update entry; writes land at the edge and are seen next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'b00;
      end
    end else if (upd_valid) begin
      if (wr_hit) begin
        if (upd_taken) begin
          btb_target[wr_idx] <= upd_target;
          if (btb_ctr[wr_idx] != 2'b11)
            btb_ctr[wr_idx] <= btb_ctr[wr_idx] + 2'b01;
        end else if (btb_ctr[wr_idx] != 2'b00) begin
          btb_ctr[wr_idx] <= btb_ctr[wr_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        btb_valid[wr_idx]  <= 1'b1;
        btb_tag[wr_idx]    <= wr_tag;
        btb_target[wr_idx] <= upd_target;
        btb_ctr[wr_idx]    <= 2'b10;
      end
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits      <= '0;
      stat_redirects <= '0;
    end else begin
      if (!stall && hit)
        stat_hits <= stat_hits + 32'd1;
      if (redirect_valid)
        stat_redirects <= stat_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_next_pc_predictor.sv
// Directed bench for next_pc_predictor: table of per-edge vectors plus hand sequences for async reset and wrap.
module tb_next_pc_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] pc, pred_target, w_pc, w_pred_target;
  logic        pred_taken, w_pred_taken;
`ifdef BTB_STATS_EN
  logic [31:0] stat_hits, stat_redirects, w_stat_hits, w_stat_redirects;
`endif

  int vec_count  = 0;
  int miss_count = 0;

  always #5 clk = ~clk;

  next_pc_predictor dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
`ifdef BTB_STATS_EN
    .stat_hits(stat_hits), .stat_redirects(stat_redirects),
`endif
    .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target)
  );

  next_pc_predictor #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
`ifdef BTB_STATS_EN
    .stat_hits(w_stat_hits), .stat_redirects(w_stat_redirects),
`endif
    .pc(w_pc), .pred_taken(w_pred_taken), .pred_target(w_pred_target)
  );

  typedef struct {
    string       name;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        ut;
    logic [31:0] exp_pc;
    logic        exp_pt;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic s, logic rv, logic [31:0] rpc, logic uv,
                              logic [31:0] upc, logic [31:0] utgt, logic ut,
                              logic [31:0] epc, logic ept, logic [31:0] etgt);
    vec_t v;
    v.name = n; v.stall = s; v.rv = rv; v.rpc = rpc; v.uv = uv; v.upc = upc;
    v.utgt = utgt; v.ut = ut; v.exp_pc = epc; v.exp_pt = ept; v.exp_tgt = etgt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] rpc, input logic uv,
                               input logic [31:0] upc, input logic [31:0] utgt, input logic ut);
    stall = s; redirect_valid = rv; redirect_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_taken = ut;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    // Each vector: inputs held for one edge, then expected pc/prediction after that edge.
    //                 name          stall rv  rpc      uv  upc     utgt     ut  exp_pc    pt  tgt
    vecs.push_back(mk("seq4",        0, 0, 32'h0,   0, 32'h0,  32'h0,   0, 32'h04,  0, 32'h0));
    vecs.push_back(mk("seq8",        0, 0, 32'h0,   0, 32'h0,  32'h0,   0, 32'h08,  0, 32'h0));
    vecs.push_back(mk("seq12",       0, 0, 32'h0,   0, 32'h0,  32'h0,   0, 32'h0C,  0, 32'h0));
    vecs.push_back(mk("alloc10",     0, 0, 32'h0,   1, 32'h10, 32'h40,  1, 32'h10,  1, 32'h40));
    vecs.push_back(mk("predjump",    0, 0, 32'h0,   0, 32'h0,  32'h0,   0, 32'h40,  0, 32'h0));
    vecs.push_back(mk("nt_to01",     0, 1, 32'h10,  1, 32'h10, 32'h99,  0, 32'h10,  0, 32'h40));
    vecs.push_back(mk("ctr01_seq",   0, 0, 32'h0,   0, 32'h0,  32'h0,   0, 32'h14,  0, 32'h0));
    vecs.push_back(mk("tk_to10",     0, 1, 32'h10,  1, 32'h10, 32'h40,  1, 32'h10,  1, 32'h40));
    vecs.push_back(mk("tk_to11",     1, 0, 32'h0,   1, 32'h10, 32'h40,  1, 32'h10,  1, 32'h40));
    vecs.push_back(mk("nt_to10",     1, 0, 32'h0,   1, 32'h10, 32'h40,  0, 32'h10,  1, 32'h40));
    vecs.push_back(mk("redir_stall", 1, 1, 32'h200, 0, 32'h0,  32'h0,   0, 32'h200, 0, 32'h0));
    vecs.push_back(mk("stall1",      1, 0, 32'h0,   0, 32'h0,  32'h0,   0, 32'h200, 0, 32'h0));
    vecs.push_back(mk("stall2",      1, 0, 32'h0,   0, 32'h0,  32'h0,   0, 32'h200, 0, 32'h0));
    vecs.push_back(mk("stall3",      1, 0, 32'h0,   0, 32'h0,  32'h0,   0, 32'h200, 0, 32'h0));
    vecs.push_back(mk("alias_evict", 0, 1, 32'h10,  1, 32'h50, 32'h80,  1, 32'h10,  0, 32'h0));
    vecs.push_back(mk("alias_miss",  0, 0, 32'h0,   0, 32'h0,  32'h0,   0, 32'h14,  0, 32'h0));
    vecs.push_back(mk("alias_hit",   0, 1, 32'h50,  0, 32'h0,  32'h0,   0, 32'h50,  1, 32'h80));
    vecs.push_back(mk("alias_jump",  0, 0, 32'h0,   0, 32'h0,  32'h0,   0, 32'h80,  0, 32'h0));
    vecs.push_back(mk("back_to50",   0, 1, 32'h50,  0, 32'h0,  32'h0,   0, 32'h50,  1, 32'h80));
    vecs.push_back(mk("same_cyc_old",0, 0, 32'h0,   1, 32'h50, 32'h100, 1, 32'h80,  0, 32'h0));
    vecs.push_back(mk("same_cyc_new",0, 1, 32'h50,  0, 32'h0,  32'h0,   0, 32'h50,  1, 32'h100));
    vecs.push_back(mk("miss_nt_noop",1, 0, 32'h0,   1, 32'h90, 32'h300, 0, 32'h50,  1, 32'h100));
  end

  initial begin
    rst = 1'b1;
    idle();
    #12;
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_pred", {31'b0, pred_taken}, 32'h0);
    checkOutput("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
`ifdef BTB_STATS_EN
    checkOutput("rst_stat_hits", stat_hits, 32'h0);
    checkOutput("rst_stat_redirects", stat_redirects, 32'h0);
`endif
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].uv,
                    vecs[i].upc, vecs[i].utgt, vecs[i].ut);
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, "_pc"}, pc, vecs[i].exp_pc);
      checkOutput({vecs[i].name, "_pt"}, {31'b0, pred_taken}, {31'b0, vecs[i].exp_pt});
      checkOutput({vecs[i].name, "_tgt"}, pred_target, vecs[i].exp_tgt);
    end

    // Asynchronous reset between edges: pc snaps back without waiting for a clock.
    idle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_pc", pc, 32'h0);
    checkOutput("async_rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
    checkOutput("async_rst_pred", {31'b0, pred_taken}, 32'h0);
`ifdef BTB_STATS_EN
    checkOutput("async_stat_hits", stat_hits, 32'h0);
    checkOutput("async_stat_redirects", stat_redirects, 32'h0);
`endif
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_pc", pc, 32'h4);
    checkOutput("wrap_pc", w_pc, 32'h0);

    applyStimulus(1'b0, 1'b1, 32'h50, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("cleared50_pc", pc, 32'h50);
    checkOutput("cleared50_pt", {31'b0, pred_taken}, 32'h0);

    // A taken update pending while reset is held must be dropped.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 32'h60, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("dropped_upd_pc", pc, 32'h20);
    checkOutput("dropped_upd_pt", {31'b0, pred_taken}, 32'h0);
    checkOutput("dropped_upd_tgt", pred_target, 32'h0);

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/next_pc_predictor.md
Name: next_pc_predictor

Overview:
Parametrised fetch-address generator for the pipelined CPU. Holds the fetch PC register and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It predicts the next fetch address each cycle. EX-stage resolution updates the BTB and forces a redirect on a mispredict, replacing the purely combinational PC+4/jump selection.

Parameters:
ADDR_W, 32, width of PC and targets
BTB_DEPTH, 16, BTB entries; power of two, ≥2; IDX_W = log2(BTB_DEPTH)
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  1  hold the PC (downstream hazard)
redirect_valid  in  1  EX detected mispredict or jr/jump; load redirect_pc
redirect_pc  in  ADDR_W  corrected fetch address
upd_valid  in  1  resolved control-transfer instruction update
upd_pc  in  ADDR_W  PC of the resolved instruction
upd_target  in  ADDR_W  resolved target address
upd_taken  in  1  resolved direction (1 = taken)
pc  out  ADDR_W  current fetch PC (registered)
pred_taken  out  1  prediction for current pc (combinational from pc and BTB)
pred_target  out  ADDR_W  predicted target for current pc (valid when pred_taken)

Behaviour:
- Reset (async, active-high): pc=RESET_PC; all BTB valid=0, counters=2'b00, tags/targets=0. pred_taken=0 while in reset.
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] ignored for lookup.
- Entry: valid, tag, target, ctr[1:0].
- Hit = valid && tag match. pred_taken = hit && ctr[1]. pred_target = entry target (0 when !hit).
- Next-PC priority at each rising edge: redirect_valid → pc=redirect_pc (overrides stall); else stall → pc unchanged; else pred_taken → pc=pred_target; else pc=pc+4 modulo 2^ADDR_W (wraps, no flag).
- Latency: redirect takes effect 1 cycle after assertion. Prediction is used in the same cycle pc is presented.
- BTB update on upd_valid at the rising edge, index/tag from upd_pc:
  - Hit, taken: ctr saturating +1 (max 2'b11); target ← upd_target.
  - Hit, not taken: ctr saturating −1 (min 2'b00); target unchanged; entry stays valid.
  - Miss, taken: allocate/overwrite the slot: valid=1, tag, target=upd_target, ctr=2'b10.
  - Miss, not taken: no change.
- Update is independent of stall and redirect; both can occur in the same cycle.
- Read/write same index in the same cycle: lookup sees the pre-update entry (no bypass). The new value is visible next cycle.
- Aliasing: a tag mismatch at an occupied index is a miss; a taken update evicts.
- Reset mid-operation clears the BTB immediately; a pending update that cycle is discarded.

Optional Feature:
BTB_STATS_EN
- Defined: adds outputs stat_hits (32) and stat_redirects (32). stat_hits += 1 each cycle with !stall && hit. stat_redirects += 1 each cycle with redirect_valid. Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset/sequential: rst pulse, no other inputs → pc=0,4,8,12 on successive edges; pred_taken=0 throughout.
- Allocate and predict: upd_valid, upd_pc=0x10, upd_target=0x40, upd_taken=1; later pc reaches 0x10 → pred_taken=1, pred_target=0x40, next pc=0x40.
- Counter hysteresis: entry for 0x10 at ctr=2'b10, one not-taken update → ctr=01, pc 0x10 → next pc 0x14. Two taken updates → ctr=11. One not-taken → ctr=10, still predicts 0x40.
- Redirect vs stall: stall=1 and redirect_valid=1 with redirect_pc=0x200 → pc=0x200 next edge. stall=1 alone → pc holds for 3 cycles.
- Aliasing (BTB_DEPTH=16): allocate 0x10→0x40, then taken update 0x50→0x80 (same index) → pc=0x10 misses (next 0x14), pc=0x50 predicts 0x80. Same-cycle update/lookup at 0x10 shows the old entry.
- Wrap/reset: RESET_PC=0xFFFF_FFFC, no hits → pc=0xFFFF_FFFC then 0x0. Assert rst mid-run after allocations → pc=RESET_PC asynchronously, previously allocated PCs no longer hit; with BTB_STATS_EN, counters read 0.
